systolic_tile_loader: RTL and testbench
=======================================

SYSTOLIC_TILE_LOADER -- requirements
Module: systolic_tile_loader

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 12, giving the number of clk cycles the array runs after its reset pulse before results are captured (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 s_valid  input  1  upstream byte valid.
REQ-005 s_data  input  8  upstream byte.
REQ-006 s_ready  output  1  loader accepts a byte this cycle.
REQ-007 img_flat  output  128  image bytes i00..i33, i00 at bits [127:120], row-major, i33 at [7:0].
REQ-008 flt_flat  output  72  filter bytes f00..f22, f00 at [71:64], row-major, f22 at [7:0].
REQ-009 sys_rst  output  1  reset to the one_by_one_systolic array; active-high.
REQ-010 res_flat  input  32  array results o00,o01,o10,o11, o00 at [31:24].
REQ-011 m_valid  output  1  downstream result byte valid.
REQ-012 m_data  output  8  downstream result byte.
REQ-013 m_ready  input  1  downstream accepts a byte.
REQ-014 busy  output  1  high in every state except LOAD.

Function
REQ-015 SHALL implement the FSM states LOAD, START, RUN and DRAIN.
REQ-016 LOAD: s_ready=1; a byte transfers when s_valid&&s_ready; transfer n (0..24) writes byte n of the concatenated sequence {i00..i33, f00..f22}.
REQ-017 Index 0..15 SHALL write the image register; index 16..24 SHALL write the filter register; a 5-bit load counter SHALL track the index.
REQ-018 The transfer at index 24 SHALL move the FSM to START on the next edge and clear the load counter.
REQ-019 START: s_ready=0; sys_rst=1 for exactly one cycle; next state RUN; the run counter loads 0.
REQ-020 RUN: sys_rst=0; the run counter increments each cycle; at count RUN_CYCLES-1 res_flat SHALL be captured into a 32-bit result register and the FSM SHALL move to DRAIN.
REQ-021 img_flat and flt_flat SHALL hold stable from START until the next LOAD write; they are driven straight from the registers.
REQ-022 DRAIN: m_valid=1; m_data = result byte k (k=0..3, o00 first); k advances only on m_valid&&m_ready.
REQ-023 When m_ready=0, m_data and m_valid SHALL hold unchanged (no byte dropped or repeated).
REQ-024 The handshake at k=3 SHALL return the FSM to LOAD with s_ready=1 on the next cycle; the image and filter registers keep their old contents until overwritten.
REQ-025 s_valid outside LOAD SHALL be ignored, with no register write and no counter change.
REQ-026 No arithmetic on data; the result bytes SHALL pass through unmodified from res_flat.
REQ-027 Latency from the index-24 transfer to the first m_valid SHALL be exactly RUN_CYCLES+2 cycles.

Reset
REQ-028 rst=1 SHALL force state LOAD, load/run/drain counters 0, image/filter/result registers 0, s_ready=1 from the first cycle after release, m_valid=0, and sys_rst=1 while rst is high.
REQ-029 Reset mid-operation (any state) SHALL discard the partial tile and any undrained results; no m_valid SHALL follow the reset.

Structure
REQ-030 A shared package SHALL hold the state encoding, TILE_BYTES=16, FILT_BYTES=9, RES_BYTES=4.
REQ-031 No sub-module SHALL be required; the bench SHALL instantiate one_by_one_systolic alongside the loader.

Verification
REQ-032 Stream 9,8,2,6,0,4,1,6,4,10,1,1,2,2,9,9 then 3,2,0,2,0,1,3,1,1 with m_ready=1 -> m_data 67,74,34,59 on four consecutive valid cycles.
REQ-033 Same stream with s_valid toggling every other cycle -> identical results; load takes 50 cycles; no extra bytes captured.
REQ-034 m_ready low for 5 cycles at k=1 -> m_data holds 74 throughout; order 67,74,34,59 preserved.
REQ-035 Assert rst after 10 bytes loaded, then stream the full 25 bytes -> results 67,74,34,59; no earlier m_valid.
REQ-036 Drive s_valid=1 with byte 0xFF throughout START/RUN/DRAIN -> the registers are unchanged; the next tile loads correctly from index 0.
REQ-037 Measure cycles from the index-24 transfer to the first m_valid -> exactly RUN_CYCLES+2 (14 at default).

Source files
------------

// File: rtl/systolic_tile_loader_pkg.sv
// Shared constants for the systolic tile loader: byte counts of the
// image tile, filter and result words, and the loader FSM state encoding.
package systolic_tile_loader_pkg;

    localparam int TILE_BYTES = 16;
    localparam int FILT_BYTES = 9;
    localparam int RES_BYTES  = 4;
    localparam int LOAD_BYTES = TILE_BYTES + FILT_BYTES;

    typedef logic [1:0] state_t;

    localparam state_t ST_LOAD  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_RUN   = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

    // Result byte k of the captured result word, o00 (k=0) first.
    function automatic logic [7:0] res_byte(
        input logic [31:0] res,
        input logic [1:0]  k
    );
        logic [7:0] b;
        b = res[31:24];
        unique case (k)
            2'd0: b = res[31:24];
            2'd1: b = res[23:16];
            2'd2: b = res[15:8];
            2'd3: b = res[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/systolic_tile_loader.sv
// Streams a 4x4 image tile and 3x3 filter into a systolic array, resets and
// runs it for RUN_CYCLES, captures the 2x2 result and drains it bytewise.
//   clk, rst           : clock, synchronous active-high reset
//   s_valid/s_data/s_ready : upstream byte stream (25 bytes per tile)
//   img_flat, flt_flat : registered image/filter towards the array
//   sys_rst            : array reset (one START cycle, and during rst)
//   res_flat           : array results o00,o01,o10,o11
//   m_valid/m_data/m_ready : downstream result bytes, o00 first
//   busy               : high whenever the loader is not in LOAD
module systolic_tile_loader
    import systolic_tile_loader_pkg::*;
#(
    parameter int RUN_CYCLES = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    input  logic [7:0]   s_data,
    output logic         s_ready,
    output logic [127:0] img_flat,
    output logic [71:0]  flt_flat,
    output logic         sys_rst,
    input  logic [31:0]  res_flat,
    output logic         m_valid,
    output logic [7:0]   m_data,
    input  logic         m_ready,
    output logic         busy
);

    state_t       r_state;
    logic [4:0]   r_ld_cnt;
    logic [7:0]   r_run_cnt;
    logic [1:0]   r_drn_cnt;
    logic [127:0] r_img;
    logic [71:0]  r_flt;
    logic [31:0]  r_res;

    logic w_s_fire;
    logic w_m_fire;
    logic w_last_byte;
    logic w_run_done;
    logic w_last_res;

    // s_valid is only honoured in LOAD; elsewhere it is ignored entirely.
    assign w_s_fire    = s_valid && (r_state == ST_LOAD);
    assign w_m_fire    = m_ready && (r_state == ST_DRAIN);
    assign w_last_byte = w_s_fire
                      && (r_ld_cnt == 5'(LOAD_BYTES - 1));
    assign w_run_done  = (r_state == ST_RUN)
                      && (r_run_cnt == 8'(RUN_CYCLES - 1));
    assign w_last_res  = w_m_fire
                      && (r_drn_cnt == 2'(RES_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_LOAD;
            r_ld_cnt  <= '0;
            r_run_cnt <= '0;
            r_drn_cnt <= '0;
            r_img     <= '0;
            r_flt     <= '0;
            r_res     <= '0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    if (w_s_fire) begin
                        // Byte n lands MSB-first: image bytes 0..15,
                        // then filter bytes 16..24.
                        for (int b = 0; b < TILE_BYTES; b++) begin
                            if (r_ld_cnt == 5'(b)) begin
                                r_img[(TILE_BYTES-1-b)*8 +: 8] <= s_data;
                            end
                        end
                        for (int b = 0; b < FILT_BYTES; b++) begin
                            if (r_ld_cnt == 5'(TILE_BYTES + b)) begin
                                r_flt[(FILT_BYTES-1-b)*8 +: 8] <= s_data;
                            end
                        end
                        if (w_last_byte) begin
                            r_ld_cnt <= '0;
                            r_state  <= ST_START;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + 5'd1;
                        end
                    end
                end
                ST_START: begin
                    r_run_cnt <= '0;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_run_done) begin
                        r_res   <= res_flat;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_run_cnt <= r_run_cnt + 8'd1;
                    end
                end
                ST_DRAIN: begin
                    if (w_last_res) begin
                        r_drn_cnt <= '0;
                        r_state   <= ST_LOAD;
                    end else if (w_m_fire) begin
                        r_drn_cnt <= r_drn_cnt + 2'd1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign s_ready  = (r_state == ST_LOAD);
    assign busy     = (r_state != ST_LOAD);
    // The array is held in reset alongside the loader.
    assign sys_rst  = rst || (r_state == ST_START);
    assign img_flat = r_img;
    assign flt_flat = r_flt;
    assign m_valid  = (r_state == ST_DRAIN);
    assign m_data   = res_byte(r_res, r_drn_cnt);

endmodule

// File: tb/tb_systolic_tile_loader.sv
// Bench for systolic_tile_loader: a behavioural 2x2 correlation array,
// a byte-level reference model and directed plus randomised tiles.
module tb_systolic_tile_loader;

    localparam int RC = 12;

    logic         clk = 0;
    logic         rst;
    logic         s_valid;
    logic [7:0]   s_data;
    logic         s_ready;
    logic [127:0] img_flat;
    logic [71:0]  flt_flat;
    logic         sys_rst;
    logic [31:0]  res_flat;
    logic         m_valid;
    logic [7:0]   m_data;
    logic         m_ready;
    logic         busy;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    systolic_tile_loader #(.RUN_CYCLES(RC)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .img_flat (img_flat),
        .flt_flat (flt_flat),
        .sys_rst  (sys_rst),
        .res_flat (res_flat),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .busy     (busy)
    );

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] want);
        vectors++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Stand-in for one_by_one_systolic: after its reset it needs a few
    // cycles before the 2x2 valid correlation appears on res_flat.
    function automatic logic [31:0] arr_conv(input logic [127:0] im,
                                             input logic [71:0] fl);
        logic [31:0] r;
        logic [7:0]  s;
        r = '0;
        for (int oi = 0; oi < 2; oi++) begin
            for (int oj = 0; oj < 2; oj++) begin
                s = 8'd0;
                for (int a = 0; a < 3; a++) begin
                    for (int b = 0; b < 3; b++) begin
                        s = 8'(s + im[127-8*((oi+a)*4+oj+b) -: 8]
                                 * fl[71-8*(a*3+b) -: 8]);
                    end
                end
                r[31-8*(oi*2+oj) -: 8] = s;
            end
        end
        return r;
    endfunction

    logic [7:0] arr_cnt = 8'd0;
    always @(posedge clk) begin
        if (sys_rst) arr_cnt <= 8'd0;
        else if (arr_cnt != 8'hFF) arr_cnt <= arr_cnt + 8'd1;
    end
    assign res_flat = (arr_cnt >= 8'd6) ? arr_conv(img_flat, flt_flat)
                                        : 32'h0;

    // Reference model: byte arrays, expected result queue, tile timing.
    logic [7:0] m_img [16];
    logic [7:0] m_flt [9];
    logic [7:0] expq [$];
    int cyc = 0;
    int nacc = 0;
    bit in_flight = 0;
    int t25 = -1000;
    bit first_seen = 1;

    function automatic logic [7:0] ref_out(input int oi, input int oj);
        logic [7:0] s;
        s = 8'd0;
        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                s = 8'(s + m_img[(oi+a)*4+oj+b] * m_flt[a*3+b]);
        return s;
    endfunction

    function automatic logic [127:0] pack_img();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = m_img[i];
        return v;
    endfunction

    function automatic logic [71:0] pack_flt();
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[71-8*i -: 8] = m_flt[i];
        return v;
    endfunction

    always @(negedge clk) begin
        bit ev_rdy;
        bit ev_mv;
        cyc++;
        if (rst) begin
            chk("sys_rst_in_rst", 128'(sys_rst), 128'(1));
            for (int i = 0; i < 16; i++) m_img[i] = 8'd0;
            for (int i = 0; i < 9; i++) m_flt[i] = 8'd0;
            nacc = 0;
            expq.delete();
            in_flight = 0;
            t25 = -1000;
            first_seen = 1;
        end else begin
            ev_rdy = !in_flight;
            ev_mv  = in_flight && (cyc >= t25 + RC + 2);
            chk("s_ready", 128'(s_ready), 128'(ev_rdy));
            chk("busy", 128'(busy), 128'(!ev_rdy));
            chk("sys_rst", 128'(sys_rst), 128'(cyc == t25 + 1));
            chk("m_valid", 128'(m_valid), 128'(ev_mv));
            chk("img_flat", img_flat, pack_img());
            chk("flt_flat", 128'(flt_flat), 128'(pack_flt()));
            if (ev_mv && expq.size() > 0)
                chk("m_data", 128'(m_data), 128'(expq[0]));
            if (in_flight && m_valid && !first_seen) begin
                first_seen = 1;
                chk("latency", 128'(cyc - t25), 128'(RC + 2));
            end
            if (ev_mv && m_ready && expq.size() > 0) begin
                void'(expq.pop_front());
                if (expq.size() == 0) in_flight = 0;
            end
            if (ev_rdy && s_valid) begin
                if (nacc < 16) m_img[nacc] = s_data;
                else m_flt[nacc-16] = s_data;
                nacc++;
                if (nacc == 25) begin
                    expq.push_back(ref_out(0, 0));
                    expq.push_back(ref_out(0, 1));
                    expq.push_back(ref_out(1, 0));
                    expq.push_back(ref_out(1, 1));
                    in_flight = 1;
                    t25 = cyc;
                    nacc = 0;
                    first_seen = 0;
                end
            end
        end
    end

    // mode 0: valid every cycle, 1: every other cycle (idle first),
    // 2: random. junk keeps s_valid high with 0xFF after the last byte.
    task automatic load_tile(input logic [7:0] b [25], input int mode,
                             input int stop_n, input bit junk,
                             output int ncyc);
        int idx;
        bit v;
        idx = 0;
        ncyc = 0;
        while (idx < stop_n && ncyc < 400) begin
            @(posedge clk); #1;
            if (mode == 0) v = 1;
            else if (mode == 1) v = ncyc[0];
            else v = 1'($urandom_range(0, 1));
            s_valid = v;
            s_data  = v ? b[idx] : 8'($urandom);
            @(negedge clk);
            ncyc++;
            if (s_valid && s_ready) idx++;
        end
        if (idx < stop_n) chk("load_timeout", 128'(idx), 128'(stop_n));
        @(posedge clk); #1;
        s_valid = junk;
        s_data  = junk ? 8'hFF : 8'h00;
    endtask

    // mode 0: m_ready high, 1: stall 5 cycles at k=1, 2: random.
    task automatic drain(input int mode, input bit lit);
        int k;
        int n;
        int stall;
        logic [7:0] want [4];
        want = '{8'd67, 8'd74, 8'd34, 8'd59};
        k = 0;
        n = 0;
        stall = 0;
        while (k < 4 && n < 300) begin
            @(posedge clk); #1;
            if (mode == 1) m_ready = !(k == 1 && stall < 5);
            else if (mode == 2) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1;
            @(negedge clk);
            n++;
            if (m_valid) begin
                if (lit) chk("lit_data", 128'(m_data), 128'(want[k]));
                if (!m_ready) stall++;
                else k++;
            end
        end
        if (k < 4) chk("drain_timeout", 128'(k), 128'(4));
        @(posedge clk); #1;
        s_valid = 0;
        s_data  = 8'h00;
        m_ready = 1;
        if (mode == 1) chk("stall_cycles", 128'(stall), 128'(5));
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1;
        s_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        logic [7:0] d [25];
        logic [7:0] rb [25];
        int nc;
        d = '{8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
              8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9,
              8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1};
        rst = 1;
        s_valid = 0;
        s_data = 8'h00;
        m_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_img", img_flat, 128'h0);
        chk("rst_flt", 128'(flt_flat), 128'h0);
        chk("rst_s_ready", 128'(s_ready), 128'(1));
        chk("rst_m_valid", 128'(m_valid), 128'(0));

        load_tile(d, 0, 25, 0, nc);
        chk("load_cycles_full", 128'(nc), 128'(25));
        drain(0, 1);

        load_tile(d, 1, 25, 0, nc);
        chk("load_cycles_toggle", 128'(nc), 128'(50));
        drain(0, 1);

        load_tile(d, 0, 25, 0, nc);
        drain(1, 1);

        load_tile(d, 0, 10, 0, nc);
        pulse_rst();
        load_tile(d, 0, 25, 0, nc);
        drain(0, 1);

        load_tile(d, 0, 25, 1, nc);
        drain(0, 1);

        load_tile(d, 0, 25, 0, nc);
        repeat (5) @(posedge clk);
        pulse_rst();
        repeat (30) @(posedge clk);

        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 25; i++) rb[i] = 8'($urandom);
            load_tile(rb, int'($urandom_range(0, 2)), 25,
                      1'($urandom_range(0, 1)), nc);
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 15)) @(posedge clk);
                pulse_rst();
            end else begin
                drain(($urandom_range(0, 1) == 0) ? 0 : 2, 0);
            end
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
